// File: rtl/nanomamba_pcen_sched_if.sv
// Scheduler-side bundle: front-end mel beats and router gate in, PCEN feed out, PCEN strobe back,
// plus expert ICG enables, mode, frame count and error pulses. The scheduler uses the slave modport.
interface nanomamba_pcen_sched_if;
  logic        mel_in_valid;
  logic [5:0]  mel_in_index;
  logic [15:0] mel_in_data;
  logic        mel_in_last;
  logic        mel_in_ready;
  logic        gate_in_valid;
  logic [7:0]  gate_in;
  logic        mel_valid;
  logic [5:0]  mel_index;
  logic [15:0] mel_out;
  logic        mel_frame_done;
  logic        gate_valid;
  logic [7:0]  gate;
  logic        pcen_valid;
  logic        en_expert0;
  logic        en_expert1;
  logic [1:0]  mode;
  logic [15:0] frame_count;
  logic        err_len;
  logic        err_overrun;
  logic        err_timeout;

  modport master (
    output mel_in_valid, mel_in_index, mel_in_data, mel_in_last, gate_in_valid, gate_in, pcen_valid,
    input  mel_in_ready, mel_valid, mel_index, mel_out, mel_frame_done, gate_valid, gate,
           en_expert0, en_expert1, mode, frame_count, err_len, err_overrun, err_timeout
  );

  modport slave (
    input  mel_in_valid, mel_in_index, mel_in_data, mel_in_last, gate_in_valid, gate_in, pcen_valid,
    output mel_in_ready, mel_valid, mel_index, mel_out, mel_frame_done, gate_valid, gate,
           en_expert0, en_expert1, mode, frame_count, err_len, err_overrun, err_timeout
  );
endinterface

// File: rtl/nanomamba_pcen_sched.sv
// DualPCEN frame scheduler + expert ICG enables; mel beats forwarded 1 cycle after acceptance, ready only in IDLE/FILL
// (other beats dropped as overrun). NANOMAMBA_PCEN_SCHED_TIMEOUT_EN adds a WAIT watchdog that aborts after TIMEOUT idle cycles.
module nanomamba_pcen_sched #(
  parameter int N_MELS      = 40,
  parameter int GATE_HI     = 240,
  parameter int GATE_LO     = 15,
  parameter int HOLD_FRAMES = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  nanomamba_pcen_sched_if.slave  bus
);
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_GWAIT, S_LAUNCH, S_DONE, S_WAIT} state_t;

  localparam logic [1:0] MODE_BOTH = 2'd0;
  localparam logic [1:0] MODE_E0   = 2'd1;
  localparam logic [1:0] MODE_E1   = 2'd2;
  localparam logic [7:0] N_MELS_C  = 8'(N_MELS);
  localparam logic [7:0] GATE_HI_C = 8'(GATE_HI);
  localparam logic [7:0] GATE_LO_C = 8'(GATE_LO);
  localparam logic [3:0] HOLD_C    = 4'(HOLD_FRAMES);

  if (TIMEOUT < 1 || TIMEOUT > 65535 || HOLD_FRAMES < 1 || HOLD_FRAMES > 15) begin : g_cfg_out_of_range
  end

  state_t      state, state_nxt;
  logic [7:0]  beat_cnt, beat_cnt_nxt;
  logic [7:0]  out_cnt, out_cnt_nxt;
  logic [3:0]  hi_cnt, hi_nxt, lo_cnt, lo_nxt;
  logic [1:0]  mode_q, mode_nxt;
  logic [7:0]  gate_q, gate_nxt, gate_lat, g;
  logic        gate_fresh, gate_fresh_nxt;
  logic        acc, len_err, fc_inc, tmo;
  logic        mel_valid_q, frame_done_q, gate_valid_q, en0_q, en1_q;
  logic        err_len_q, err_ovr_q, err_tmo_q;
  logic [5:0]  mel_index_q;
  logic [15:0] mel_out_q, frame_count_q;

  assign bus.mel_in_ready = !rst && (state == S_IDLE || state == S_FILL);
  assign acc              = bus.mel_in_valid && bus.mel_in_ready;

`ifdef NANOMAMBA_PCEN_SCHED_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
  logic [15:0] wd_cnt;

  // Cycles spent in WAIT since the most recent PCEN strobe.
  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT) wd_cnt <= '0;
    else if (bus.pcen_valid)    wd_cnt <= 16'd1;
    else                        wd_cnt <= wd_cnt + 16'd1;
  end

  assign tmo = (state == S_WAIT) && !bus.pcen_valid && (wd_cnt + 16'd1 == TIMEOUT_C);
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    beat_cnt_nxt   = beat_cnt;
    out_cnt_nxt    = out_cnt;
    hi_nxt         = hi_cnt;
    lo_nxt         = lo_cnt;
    mode_nxt       = mode_q;
    gate_nxt       = gate_q;
    gate_fresh_nxt = gate_fresh | bus.gate_in_valid;
    g              = bus.gate_in_valid ? bus.gate_in : gate_lat;
    len_err        = 1'b0;
    fc_inc         = 1'b0;
    case (state)
      S_IDLE, S_FILL: begin
        if (acc) begin
          beat_cnt_nxt = (state == S_IDLE) ? 8'd1 : beat_cnt + 8'd1;
          state_nxt    = S_FILL;
          if (bus.mel_in_last) begin
            if (beat_cnt_nxt == N_MELS_C) begin
              state_nxt = S_GWAIT;
            end else begin
              len_err   = 1'b1;
              state_nxt = S_IDLE;
            end
          end
        end
      end
      S_GWAIT: begin
        if (gate_fresh || bus.gate_in_valid) begin
          state_nxt      = S_LAUNCH;
          gate_fresh_nxt = 1'b0;
          // Counters saturate at the hold depth; any non-qualifying frame resets both.
          if (g >= GATE_HI_C) begin
            hi_nxt = (hi_cnt >= HOLD_C) ? HOLD_C : hi_cnt + 4'd1;
            lo_nxt = 4'd0;
          end else if (g <= GATE_LO_C) begin
            lo_nxt = (lo_cnt >= HOLD_C) ? HOLD_C : lo_cnt + 4'd1;
            hi_nxt = 4'd0;
          end else begin
            hi_nxt = 4'd0;
            lo_nxt = 4'd0;
          end
          if (hi_nxt == HOLD_C)      mode_nxt = MODE_E1;
          else if (lo_nxt == HOLD_C) mode_nxt = MODE_E0;
          else                       mode_nxt = MODE_BOTH;
          case (mode_nxt)
            MODE_E0: gate_nxt = 8'd0;
            MODE_E1: gate_nxt = 8'd255;
            default: gate_nxt = g;
          endcase
        end
      end
      S_LAUNCH: state_nxt = S_DONE;
      S_DONE: begin
        out_cnt_nxt = 8'd0;
        state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        if (bus.pcen_valid) begin
          out_cnt_nxt = out_cnt + 8'd1;
          if (out_cnt_nxt == N_MELS_C) begin
            fc_inc    = 1'b1;
            state_nxt = S_IDLE;
          end
        end else if (tmo) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt      <= '0;
      out_cnt       <= '0;
      hi_cnt        <= '0;
      lo_cnt        <= '0;
      mode_q        <= MODE_BOTH;
      gate_q        <= 8'd128;
      gate_lat      <= 8'd128;
      gate_fresh    <= 1'b0;
      mel_valid_q   <= 1'b0;
      mel_index_q   <= '0;
      mel_out_q     <= '0;
      frame_done_q  <= 1'b0;
      gate_valid_q  <= 1'b0;
      en0_q         <= 1'b0;
      en1_q         <= 1'b0;
      err_len_q     <= 1'b0;
      err_ovr_q     <= 1'b0;
      err_tmo_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      beat_cnt     <= beat_cnt_nxt;
      out_cnt      <= out_cnt_nxt;
      hi_cnt       <= hi_nxt;
      lo_cnt       <= lo_nxt;
      mode_q       <= mode_nxt;
      gate_q       <= gate_nxt;
      gate_fresh   <= gate_fresh_nxt;
      if (bus.gate_in_valid) gate_lat <= bus.gate_in;
      mel_valid_q  <= acc;
      if (acc) begin
        mel_index_q <= bus.mel_in_index;
        mel_out_q   <= bus.mel_in_data;
      end
      frame_done_q <= (state_nxt == S_DONE);
      gate_valid_q <= (state_nxt == S_LAUNCH);
      // Enables follow the next state so they line up with the registered state they cover.
      en0_q        <= (state_nxt != S_IDLE);
      en1_q        <= (state_nxt == S_LAUNCH || state_nxt == S_DONE || state_nxt == S_WAIT) &&
                      (mode_nxt != MODE_E0);
      err_len_q    <= len_err;
      err_ovr_q    <= bus.mel_in_valid && !bus.mel_in_ready;
      err_tmo_q    <= tmo;
      if (fc_inc) frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign bus.mel_valid      = mel_valid_q;
  assign bus.mel_index      = mel_index_q;
  assign bus.mel_out        = mel_out_q;
  assign bus.mel_frame_done = frame_done_q;
  assign bus.gate_valid     = gate_valid_q;
  assign bus.gate           = gate_q;
  assign bus.en_expert0     = en0_q;
  assign bus.en_expert1     = en1_q;
  assign bus.mode           = mode_q;
  assign bus.frame_count    = frame_count_q;
  assign bus.err_len        = err_len_q;
  assign bus.err_overrun    = err_ovr_q;
  assign bus.err_timeout    = err_tmo_q;
endmodule

// File: tb/tb_nanomamba_pcen_sched.sv
// Directed bench for nanomamba_pcen_sched: nominal frame, hysteresis, short frame, late gate, overrun,
// WAIT stall (timeout when NANOMAMBA_PCEN_SCHED_TIMEOUT_EN is defined) and mid-frame reset.
module tb_nanomamba_pcen_sched;
  localparam int N = 40;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   fc_exp      = 0;

  nanomamba_pcen_sched_if bus();

  nanomamba_pcen_sched #(
    .N_MELS(N), .GATE_HI(240), .GATE_LO(15), .HOLD_FRAMES(4), .TIMEOUT(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beats(input int n, input bit with_last, input bit with_gate, input logic [7:0] gv);
    for (int i = 0; i < n; i++) begin
      bus.mel_in_valid  = 1'b1;
      bus.mel_in_index  = 6'(i);
      bus.mel_in_data   = 16'(32'h1000 + i);
      bus.mel_in_last   = with_last && (i == n - 1);
      bus.gate_in_valid = with_gate && (i == n - 1);
      bus.gate_in       = gv;
      tick();
      if (i == 0) begin
        chk("fwd_first_vld", 32'(bus.mel_valid), 1);
        chk("fwd_first_dat", 32'(bus.mel_out), 32'h1000);
        chk("en0_rise", 32'(bus.en_expert0), 1);
      end
      if (i == n - 1) chk("fwd_last_idx", 32'(bus.mel_index), 32'(n - 1));
    end
    bus.mel_in_valid  = 1'b0;
    bus.mel_in_last   = 1'b0;
    bus.gate_in_valid = 1'b0;
  endtask

  task automatic pcen(input int n);
    for (int i = 0; i < n; i++) begin
      bus.pcen_valid = 1'b1;
      tick();
    end
    bus.pcen_valid = 1'b0;
  endtask

  // Checks from LAUNCH up to first WAIT cycle; entered one cycle after the last beat (GWAIT).
  task automatic launch_checks(input logic [1:0] exp_mode, input logic [7:0] exp_gate, input bit exp_en1);
    tick();
    chk("launch_gate_valid", 32'(bus.gate_valid), 1);
    chk("launch_gate", 32'(bus.gate), 32'(exp_gate));
    chk("launch_mode", 32'(bus.mode), 32'(exp_mode));
    chk("launch_en1", 32'(bus.en_expert1), 32'(exp_en1));
    chk("launch_no_done", 32'(bus.mel_frame_done), 0);
    tick();
    chk("done_pulse", 32'(bus.mel_frame_done), 1);
    chk("done_gate_valid_low", 32'(bus.gate_valid), 0);
    chk("done_en1", 32'(bus.en_expert1), 32'(exp_en1));
    tick();
    chk("wait_done_low", 32'(bus.mel_frame_done), 0);
    chk("wait_en0", 32'(bus.en_expert0), 1);
    chk("wait_en1", 32'(bus.en_expert1), 32'(exp_en1));
  endtask

  task automatic launch_frame(input logic [7:0] gv, input logic [1:0] exp_mode, input logic [7:0] exp_gate, input bit exp_en1);
    send_beats(N, 1'b1, 1'b1, gv);
    chk("gwait_gate_valid", 32'(bus.gate_valid), 0);
    chk("gwait_en1", 32'(bus.en_expert1), 0);
    launch_checks(exp_mode, exp_gate, exp_en1);
  endtask

  task automatic finish_frame(input int n);
    pcen(n);
    fc_exp++;
    chk("frame_count", 32'(bus.frame_count), 32'(fc_exp));
    chk("idle_en0", 32'(bus.en_expert0), 0);
    chk("idle_en1", 32'(bus.en_expert1), 0);
    chk("idle_ready", 32'(bus.mel_in_ready), 1);
  endtask

  initial begin
    rst               = 1'b1;
    bus.mel_in_valid  = 1'b0;
    bus.mel_in_index  = '0;
    bus.mel_in_data   = '0;
    bus.mel_in_last   = 1'b0;
    bus.gate_in_valid = 1'b0;
    bus.gate_in       = '0;
    bus.pcen_valid    = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(bus.mel_in_ready), 0);
    chk("rst_en0", 32'(bus.en_expert0), 0);
    chk("rst_en1", 32'(bus.en_expert1), 0);
    chk("rst_gate", 32'(bus.gate), 128);
    chk("rst_mode", 32'(bus.mode), 0);
    chk("rst_fc", 32'(bus.frame_count), 0);
    chk("rst_mel_valid", 32'(bus.mel_valid), 0);
    chk("rst_mel_out", 32'(bus.mel_out), 0);
    chk("rst_gate_valid", 32'(bus.gate_valid), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.mel_in_ready), 1);

    // Nominal frame, then hysteresis toward E1 and E0 and back to BOTH.
    launch_frame(8'd100, 2'd0, 8'd100, 1'b1);
    finish_frame(N);
    for (int f = 0; f < 3; f++) begin
      launch_frame(8'd250, 2'd0, 8'd250, 1'b1);
      finish_frame(N);
    end
    launch_frame(8'd250, 2'd2, 8'd255, 1'b1);
    finish_frame(N);
    for (int f = 0; f < 3; f++) begin
      launch_frame(8'd10, 2'd0, 8'd10, 1'b1);
      finish_frame(N);
    end
    launch_frame(8'd10, 2'd1, 8'd0, 1'b0);
    finish_frame(N);
    launch_frame(8'd128, 2'd0, 8'd128, 1'b1);
    finish_frame(N);

    // Short frame is dropped, next frame runs normally.
    send_beats(N - 1, 1'b1, 1'b0, 8'd0);
    chk("short_err_len", 32'(bus.err_len), 1);
    chk("short_en0", 32'(bus.en_expert0), 0);
    chk("short_ready", 32'(bus.mel_in_ready), 1);
    tick();
    chk("short_err_len_low", 32'(bus.err_len), 0);
    chk("short_no_done", 32'(bus.mel_frame_done), 0);
    chk("short_no_gate_valid", 32'(bus.gate_valid), 0);
    launch_frame(8'd128, 2'd0, 8'd128, 1'b1);
    finish_frame(N);

    // Late gate, overrun in WAIT, then last strobe colliding with a new beat.
    send_beats(N, 1'b1, 1'b0, 8'd0);
    repeat (19) tick();
    chk("late_no_gate_valid", 32'(bus.gate_valid), 0);
    bus.gate_in_valid = 1'b1;
    bus.gate_in       = 8'd50;
    launch_checks(2'd0, 8'd50, 1'b1);
    bus.gate_in_valid = 1'b0;
    bus.mel_in_valid  = 1'b1;
    bus.mel_in_index  = 6'd5;
    chk("wait_ready_low", 32'(bus.mel_in_ready), 0);
    tick();
    bus.mel_in_valid = 1'b0;
    chk("overrun_pulse", 32'(bus.err_overrun), 1);
    chk("overrun_no_fwd", 32'(bus.mel_valid), 0);
    tick();
    chk("overrun_low", 32'(bus.err_overrun), 0);
    pcen(N - 1);
    bus.pcen_valid   = 1'b1;
    bus.mel_in_valid = 1'b1;
    tick();
    bus.pcen_valid   = 1'b0;
    bus.mel_in_valid = 1'b0;
    fc_exp++;
    chk("collide_overrun", 32'(bus.err_overrun), 1);
    chk("collide_no_fwd", 32'(bus.mel_valid), 0);
    chk("collide_fc", 32'(bus.frame_count), 32'(fc_exp));
    chk("collide_en0", 32'(bus.en_expert0), 0);

    // PCEN stalls after 10 strobes.
    launch_frame(8'd200, 2'd0, 8'd200, 1'b1);
    pcen(10);
    repeat (48) tick();
    chk("stall_tmo_quiet", 32'(bus.err_timeout), 0);
    chk("stall_en0", 32'(bus.en_expert0), 1);
    tick();
`ifdef NANOMAMBA_PCEN_SCHED_TIMEOUT_EN
    chk("timeout_pulse", 32'(bus.err_timeout), 1);
    chk("timeout_en0", 32'(bus.en_expert0), 0);
    chk("timeout_fc", 32'(bus.frame_count), 32'(fc_exp));
    tick();
    chk("timeout_low", 32'(bus.err_timeout), 0);
`else
    chk("no_timeout", 32'(bus.err_timeout), 0);
    chk("still_wait_en0", 32'(bus.en_expert0), 1);
    finish_frame(N - 10);
`endif

    // Reset while WAITing in E1_ONLY mode.
    for (int f = 0; f < 3; f++) begin
      launch_frame(8'd250, 2'd0, 8'd250, 1'b1);
      finish_frame(N);
    end
    launch_frame(8'd250, 2'd2, 8'd255, 1'b1);
    pcen(5);
    rst = 1'b1;
    tick();
    chk("mid_rst_mode", 32'(bus.mode), 0);
    chk("mid_rst_gate", 32'(bus.gate), 128);
    chk("mid_rst_en0", 32'(bus.en_expert0), 0);
    chk("mid_rst_en1", 32'(bus.en_expert1), 0);
    chk("mid_rst_fc", 32'(bus.frame_count), 0);
    chk("mid_rst_errs", 32'({bus.err_len, bus.err_overrun, bus.err_timeout}), 0);
    rst = 1'b0;
    fc_exp = 0;
    #1;
    chk("mid_rst_ready", 32'(bus.mel_in_ready), 1);
    launch_frame(8'd100, 2'd0, 8'd100, 1'b1);
    finish_frame(N);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/nanomamba_pcen_sched.md
# nanomamba_pcen_sched

Frame scheduler and expert clock-enable controller in front of the NanoMamba DualPCEN datapath. It accepts mel frames from the front end and the MOE router gate, forwards both to the PCEN in the order the PCEN control FSM needs, and waits for the 40 blended outputs. It decides per frame which PCEN expert clocks must run, using a hysteresis-filtered gate. It drives the ICG enables for `clk_expert0` and `clk_expert1`.

## Interface
- `N_MELS`, 40: mel bands per frame.
- `GATE_HI`, 240: gate value at or above which expert1 alone is sufficient.
- `GATE_LO`, 15: gate value at or below which expert0 alone is sufficient.
- `HOLD_FRAMES`, 4: consecutive qualifying frames required before gating an expert off (1..15).
- `TIMEOUT`, 1023: maximum cycles in WAIT before abort (≤ 65535).
- `clk` in 1: single clock. Free-running, not gated.
- `rst` in 1: synchronous, active-high reset.
- `mel_in_valid` in 1, `mel_in_index` in 6, `mel_in_data` in 16, `mel_in_last` in 1: front-end mel beats.
- `mel_in_ready` out 1: scheduler accepts mel beats.
- `gate_in_valid` in 1, `gate_in` in 8: MOE router gate, Q0.8.
- `mel_valid` out 1, `mel_index` out 6, `mel_out` out 16, `mel_frame_done` out 1: to PCEN.
- `gate_valid` out 1, `gate` out 8: effective gate to PCEN.
- `pcen_valid` in 1: PCEN output strobe.
- `en_expert0` out 1, `en_expert1` out 1: ICG enables.
- `mode` out 2: 0 = BOTH, 1 = E0_ONLY, 2 = E1_ONLY.
- `frame_count` out 16: completed frames, wraps at 0xFFFF to 0.
- `err_len` out 1, `err_overrun` out 1, `err_timeout` out 1: single-cycle error pulses.

## Operation
- **States:** IDLE, FILL, GWAIT, LAUNCH, DONE, WAIT.
- **Mel forwarding:**
  - `mel_in_ready` = 1 in IDLE and FILL only.
  - An accepted beat is forwarded registered, one cycle later, on `mel_valid`/`mel_index`/`mel_out`.
  - A beat counter increments per accepted beat.
- **Frame entry:** IDLE → FILL on the first accepted beat. The counter restarts at 1.
- **Frame end (FILL, beat with `mel_in_last`):**
  - If count = `N_MELS`: go to GWAIT.
  - Otherwise: pulse `err_len`, drop the frame (no `mel_frame_done`), go to IDLE.
- **Gate latch:**
  - `gate_in` is latched on `gate_in_valid` in any state and sets `gate_fresh`.
  - If a gate arrives while `gate_fresh` is already set, the new value overwrites the old.
- **GWAIT → LAUNCH** when `gate_fresh` is set. This can happen in the same cycle as the gate arrives, using the `gate_in` value.
- **Hysteresis** is evaluated once per frame on entry to LAUNCH, with gate value g:
  - g ≥ `GATE_HI`: hi_cnt += 1 (saturates at `HOLD_FRAMES`), lo_cnt = 0.
  - g ≤ `GATE_LO`: lo_cnt += 1 (saturates at `HOLD_FRAMES`), hi_cnt = 0.
  - Otherwise: hi_cnt = 0 and lo_cnt = 0.
- **Mode update** (same evaluation):
  - hi_cnt = `HOLD_FRAMES` → E1_ONLY.
  - lo_cnt = `HOLD_FRAMES` → E0_ONLY.
  - Otherwise → BOTH.
  - Leaving a single-expert mode is therefore immediate; entering one is delayed.
- **Effective gate:** E0_ONLY → 0, E1_ONLY → 255, BOTH → g.
- **LAUNCH:** pulse `gate_valid` with the effective gate, clear `gate_fresh`, go to DONE.
- **DONE:** pulse `mel_frame_done`, clear the output counter, go to WAIT.
- **WAIT:**
  - Count `pcen_valid` strobes.
  - At the `N_MELS`-th strobe: `frame_count` += 1, go to IDLE.
  - Extra strobes outside WAIT are ignored.
- **Clock enables** (registered, aligned with the registered state):
  - `en_expert0` = 1 in every state except IDLE. This covers the PCEN control FSM and mel buffering.
  - `en_expert1` = 1 in LAUNCH, DONE and WAIT when mode ≠ E0_ONLY.
- **Overrun:** `mel_in_valid` while `mel_in_ready` = 0 → pulse `err_overrun`, beat dropped, state unchanged.
- **Simultaneous events:**
  - `mel_in_last` and `gate_in_valid` in the same cycle: both are honoured. The next cycle is GWAIT with `gate_fresh` set.
  - Final `pcen_valid` and a new `mel_in_valid` in the same cycle: the beat is rejected as an overrun (ready = 0 in WAIT).

## Timing
- **Reset values:**
  - All pulses and strobes = 0, `mel_in_ready` = 0 during reset, `en_expert0/1` = 0.
  - `gate` = 128, `mode` = BOTH, `frame_count` = 0, hi_cnt = lo_cnt = 0, `gate_fresh` = 0.
  - `mel_index`/`mel_out` = 0, state = IDLE.
  - Reset mid-frame aborts everything with no error pulse.
- **Mel path:** accepted beat to `mel_valid` = 1 cycle.
- **Frame launch:**
  - Last beat to `gate_valid` ≥ 2 cycles (exactly 2 if the gate is already fresh).
  - `gate_valid` precedes `mel_frame_done` by exactly 1 cycle.
  - `mel_frame_done` precedes the first cycle of WAIT by 1 cycle.
- **Enable lead time:** `en_expert0` rises in the same cycle as the first forwarded `mel_valid`. `en_expert1` rises in the same cycle as `gate_valid`.
- **Pulse width:** all pulses are exactly 1 cycle.

## Configuration
- `NANOMAMBA_PCEN_SCHED_TIMEOUT_EN` defined:
  - A 16-bit watchdog counts cycles in WAIT since the last `pcen_valid`.
  - When it reaches `TIMEOUT`: pulse `err_timeout`, go to IDLE, `frame_count` unchanged.
- Undefined: WAIT waits indefinitely and `err_timeout` is tied to 0.

## Test plan
- **Nominal frame:** 40 beats, gate 100 → `gate_valid`/`gate` = 100 then `mel_frame_done` next cycle; 40 `pcen_valid` → `frame_count` = 1, IDLE, `en_expert0` = 0.
- **Hysteresis:**
  - Frames with gate 250 ×4 → `mode` = 2 from the 4th frame, `gate` = 255, `en_expert1` = 1 (mode ≠ E0_ONLY).
  - Gate 10 ×4 → `mode` = 1 on the 4th, `en_expert1` = 0 throughout that frame.
  - One frame at gate 128 → `mode` = 0 immediately.
- **Short frame:** 39 beats with last → `err_len` pulse, no `mel_frame_done`, next 40-beat frame processed normally.
- **Late gate and overrun:**
  - Gate arrives 20 cycles after the last beat → `gate_valid` one cycle after arrival.
  - A beat sent during WAIT → `err_overrun`, no `mel_valid`.
- **Timeout** (macro defined, `TIMEOUT` = 50): only 10 `pcen_valid` → `err_timeout` 50 cycles after the 10th strobe, `frame_count` unchanged.
- **Reset:** `rst` asserted in WAIT → next cycle IDLE, `mode` = 0, `gate` = 128, all enables 0.
